fire_anim_ctrl: RTL and testbench
=================================

# fire_anim_ctrl

Per-frame animation controller for the oil-drum fire sprite. It sits directly upstream of the fire colour stage. It drives that stage's `animation_state`, `isplay`, `posx` and `posy` inputs from game events (ignite, extinguish) and the VGA frame tick. It sequences the fire through an ignition blink phase and a steady two-frame burning loop. All visible changes are committed only at frame boundaries, so a sprite never tears mid-scan.

## Interface
Parameters:
- `FIRE_X`, default 10'd40: sprite left-up corner x, driven on `posx`.
- `FIRE_Y`, default 9'd260: sprite left-up corner y, driven on `posy`.
- `FRAMES_PER_STATE`, default 8: frames per animation image while burning; legal range 1..255.
- `BLINK_PERIOD`, default 4: frames per on/off half-period during ignition; legal range 1..255.
- `IGNITE_FRAMES`, default 16: length of the ignition phase in frames; legal range 1..255.

Ports:
- `clk`, in, 1: system clock, shared with the VGA controller.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame at start of vertical blank.
- `enable`, in, 1: game running; low pauses the block.
- `ignite`, in, 1: one-cycle event, fire starts.
- `extinguish`, in, 1: one-cycle event, fire removed (level reset or death).
- `animation_state`, out, 1: image select for the colour stage; 0 = image 1, 1 = image 2.
- `isplay`, out, 1: sprite visible.
- `posx`, out, 10: constant `FIRE_X`.
- `posy`, out, 9: constant `FIRE_Y`.
- `burning`, out, 1: high while the state is BURNING; intended for the collision logic.

## Operation
- States: OFF, IGNITING, BURNING. Encoding is 2 bits and comes from the shared header.
- Event latching:
  - `ignite` and `extinguish` set the sticky flags `ign_pend` and `ext_pend` on any cycle, regardless of `enable`.
  - Both flags are consumed and cleared on the next effective tick.
- Effective tick: `frame_tick & enable`. Every state and counter update happens only on an effective tick.
- When `enable` is low, all state, counters and outputs hold. Pending flags still latch.
- On each effective tick, the first matching rule applies:
  1. `ext_pend`: go to OFF. `isplay` = 0, `animation_state` = 0, counters cleared. An `ign_pend` raised in the same window is discarded; extinguish wins.
  2. OFF with `ign_pend`: go to IGNITING. `ign_cnt` = 0, `isplay` = 1.
  3. IGNITING:
     - `ign_cnt` increments.
     - When `ign_cnt` == `IGNITE_FRAMES`, go to BURNING: `isplay` = 1, `animation_state` = 0, `anim_cnt` = 0.
     - Otherwise `isplay` = ((`ign_cnt` / `BLINK_PERIOD`) even).
  4. BURNING:
     - `anim_cnt` increments.
     - When it reaches `FRAMES_PER_STATE`, it wraps to 0 and `animation_state` toggles.
- An `ign_pend` consumed in IGNITING or BURNING is ignored.
- Counters are 8 bits. Each compare-and-clear happens before wrap, so no counter overflows within the legal parameter ranges.
- `posx` and `posy` are tied to their parameters.

## Timing
- Reset values (asynchronous, applied while `rst_n` = 0):
  - State is OFF.
  - `animation_state`, `isplay`, `ign_pend`, `ext_pend`, `ign_cnt` and `anim_cnt` are all 0.
  - `burning` is 0.
- Latency: with an effective tick at cycle t, the new `isplay`, `animation_state` and state are visible at t+1. `burning` follows the state register with no extra cycle.
- An event arriving in the same cycle as `frame_tick` counts for that tick. The flag set and the consume happen in the same cycle.
- Reset asserted mid-ignition or mid-burn returns to OFF immediately. Pending events are lost.
- `frame_tick` asserted for more than one cycle is illegal. The bench must assert that it never happens.

## Structure
- Shared header `fire_defs.vh`:
  - State encodings `FIRE_OFF` = 2'd0, `FIRE_IGNITING` = 2'd1, `FIRE_BURNING` = 2'd2.
  - Counter width `FIRE_CNT_W` = 8.
- One sub-module, `frame_divider`, is used twice (ignition blink/length and burning animation). It is a parameterised 8-bit tick counter with `clear`, `en` and `count` outputs, plus a terminal-count flag.

## Test plan
Defaults apply (`FRAMES_PER_STATE` = 8, `BLINK_PERIOD` = 4, `IGNITE_FRAMES` = 16). `enable` = 1 unless stated. Tick k is the first tick after `ignite`.
- Reset: hold `rst_n` low mid-burn, drive random events. Required: all outputs 0 asynchronously, `posx` = 40, `posy` = 260.
- Ignition blink: pulse `ignite`, then 16 ticks. Required:
  - `isplay` = 1 after ticks k..k+3, 0 after k+4..k+7, 1 after k+8..k+11, 0 after k+12..k+15.
  - At k+16: `burning` = 1, `isplay` = 1, `animation_state` = 0.
- Burning loop: continue from the ignition case. Required: `animation_state` toggles at ticks k+24, k+32 and k+40, and never between ticks.
- Simultaneous events: `ignite` and `extinguish` in the same cycle while BURNING, and separately while OFF. Required: OFF with `isplay` = 0 after the next tick in both cases.
- Pause: deassert `enable` at k+20 for 10 ticks, pulsing `extinguish` meanwhile. Required: outputs frozen during the pause. OFF at the first tick after `enable` returns.
- Mid-frame event: `ignite` 100 cycles after a tick. Required: `isplay` stays 0 until the cycle after the next `frame_tick`.

Source files
------------

// File: rtl/fire_anim_ctrl_pkg.sv
// Shared definitions for the oil-drum fire animation controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fire_anim_ctrl_pkg;

  localparam int FIRE_CNT_W = 8;

  typedef logic [FIRE_CNT_W-1:0] fire_cnt_t;

  typedef enum logic [1:0] {
    FIRE_OFF      = 2'd0,
    FIRE_IGNITING = 2'd1,
    FIRE_BURNING  = 2'd2
  } fire_state_e;

  // Sprite is lit during even-numbered blink half-periods of the ignition phase.
  function automatic logic blink_on(input fire_cnt_t cnt, input fire_cnt_t half_period);
    fire_cnt_t phase;
    phase = cnt / half_period;
    return ~phase[0];
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Frame-tick counter: counts enabled ticks and wraps to zero on reaching TERM.
// Latency: count updates one cycle after en/clear; tc is combinational from count.
// Backpressure: none; clear has priority over en, idle when en is low.
module frame_divider
  import fire_anim_ctrl_pkg::*;
#(
  parameter int TERM = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear,
  input  logic      en,
  output fire_cnt_t count,
  output logic      tc
);

  localparam logic [FIRE_CNT_W:0] TERM_W = (FIRE_CNT_W + 1)'(TERM);
  localparam logic [FIRE_CNT_W:0] ONE_W  = (FIRE_CNT_W + 1)'(1);

  // tc flags that the next enabled tick lands on TERM; compared one bit wider
  // so a count of 255 can never alias to a small terminal value.
  assign tc = (({1'b0, count} + ONE_W) == TERM_W);

  // Count register: clear wins, otherwise increment and wrap at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + fire_cnt_t'(1);
    end
  end

endmodule

// File: rtl/fire_anim_ctrl.sv
// Fire sprite animation controller: ignition blink, then two-image burning loop.
// Latency: state, isplay and animation_state change the cycle after an effective frame tick.
// Backpressure: none; enable low freezes everything while ignite/extinguish stay latched.
module fire_anim_ctrl
  import fire_anim_ctrl_pkg::*;
#(
  parameter logic [9:0] FIRE_X           = 10'd40,
  parameter logic [8:0] FIRE_Y           = 9'd260,
  parameter int         FRAMES_PER_STATE = 8,
  parameter int         BLINK_PERIOD     = 4,
  parameter int         IGNITE_FRAMES    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       ignite,
  input  logic       extinguish,
  output logic       animation_state,
  output logic       isplay,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       burning
);

  localparam fire_cnt_t BLINK_HALF = fire_cnt_t'(BLINK_PERIOD);

  fire_state_e state_q, state_d;
  logic        isplay_d, anim_d;
  logic        ign_pend, ext_pend;
  logic        eff_tick, ign_now, ext_now;
  logic        ign_clr, ign_en, ign_tc;
  logic        anim_clr, anim_en, anim_tc;
  fire_cnt_t   ign_cnt, anim_cnt, ign_nxt;

  assign posx     = FIRE_X;
  assign posy     = FIRE_Y;
  assign burning  = (state_q == FIRE_BURNING);
  assign eff_tick = frame_tick & enable;
  // An event arriving on the tick cycle itself counts for that tick.
  assign ign_now  = ign_pend | ignite;
  assign ext_now  = ext_pend | extinguish;
  assign ign_nxt  = ign_cnt + fire_cnt_t'(1);

  frame_divider #(.TERM(IGNITE_FRAMES)) u_ign_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ign_clr),
    .en    (ign_en),
    .count (ign_cnt),
    .tc    (ign_tc)
  );

  frame_divider #(.TERM(FRAMES_PER_STATE)) u_anim_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (anim_clr),
    .en    (anim_en),
    .count (anim_cnt),
    .tc    (anim_tc)
  );

  // Sticky event flags: set on any cycle, consumed by the next effective tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ign_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else if (eff_tick) begin
      ign_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else begin
      if (ignite)     ign_pend <= 1'b1;
      if (extinguish) ext_pend <= 1'b1;
    end
  end

  // State and visible outputs, committed only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= FIRE_OFF;
      isplay          <= 1'b0;
      animation_state <= 1'b0;
    end else begin
      state_q         <= state_d;
      isplay          <= isplay_d;
      animation_state <= anim_d;
    end
  end

  // Next-state rules; extinguish outranks everything, stray ignites are dropped.
  always_comb begin
    state_d  = state_q;
    isplay_d = isplay;
    anim_d   = animation_state;
    ign_clr  = 1'b0;
    ign_en   = 1'b0;
    anim_clr = 1'b0;
    anim_en  = 1'b0;
    if (eff_tick) begin
      if (ext_now) begin
        state_d  = FIRE_OFF;
        isplay_d = 1'b0;
        anim_d   = 1'b0;
        ign_clr  = 1'b1;
        anim_clr = 1'b1;
      end else begin
        case (state_q)
          FIRE_OFF: begin
            if (ign_now) begin
              state_d  = FIRE_IGNITING;
              isplay_d = 1'b1;
              ign_clr  = 1'b1;
            end
          end
          FIRE_IGNITING: begin
            if (ign_tc) begin
              state_d  = FIRE_BURNING;
              isplay_d = 1'b1;
              anim_d   = 1'b0;
              ign_clr  = 1'b1;
              anim_clr = 1'b1;
            end else begin
              ign_en   = 1'b1;
              isplay_d = blink_on(ign_nxt, BLINK_HALF);
            end
          end
          FIRE_BURNING: begin
            anim_en = 1'b1;
            if (anim_tc) anim_d = ~animation_state;
          end
          default: begin
            state_d  = FIRE_OFF;
            isplay_d = 1'b0;
            anim_d   = 1'b0;
            ign_clr  = 1'b1;
            anim_clr = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fire_anim_ctrl.sv
// Self-checking bench for fire_anim_ctrl: directed scenarios plus random events.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: n/a; the bench drives every input each cycle.
module tb_fire_anim_ctrl;

  localparam int IGN = 16;
  localparam int BLK = 4;
  localparam int FPS = 8;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       enable;
  logic       ignite;
  logic       extinguish;
  logic       animation_state;
  logic       isplay;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       burning;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the fire is either out, or lit for m_f effective ticks
  // since the ignition tick; everything visible is a function of m_f.
  bit m_on;
  int m_f;
  bit m_ip;
  bit m_ep;

  fire_anim_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_tick      (frame_tick),
    .enable          (enable),
    .ignite          (ignite),
    .extinguish      (extinguish),
    .animation_state (animation_state),
    .isplay          (isplay),
    .posx            (posx),
    .posy            (posy),
    .burning         (burning)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // frame_tick is a single-cycle pulse by contract.
  assert property (@(posedge clk) disable iff (!rst_n) frame_tick |=> !frame_tick)
    else $error("frame_tick held high for more than one cycle");

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_isplay();
    if (!m_on) return 1'b0;
    if (m_f >= IGN) return 1'b1;
    return ((m_f / BLK) % 2) == 0;
  endfunction

  function automatic logic exp_anim();
    if (!m_on || m_f < IGN) return 1'b0;
    return ((m_f - IGN) / FPS) % 2 == 1;
  endfunction

  function automatic logic exp_burn();
    return m_on && (m_f >= IGN);
  endfunction

  task automatic model_reset();
    m_on = 1'b0;
    m_f  = 0;
    m_ip = 1'b0;
    m_ep = 1'b0;
  endtask

  task automatic model_clock(input bit tick, input bit en, input bit ig, input bit ex);
    m_ip = m_ip | ig;
    m_ep = m_ep | ex;
    if (tick && en) begin
      if (m_ep) begin
        m_on = 1'b0;
      end else if (!m_on && m_ip) begin
        m_on = 1'b1;
        m_f  = 0;
      end else if (m_on) begin
        m_f++;
      end
      m_ip = 1'b0;
      m_ep = 1'b0;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".isplay"},  isplay,          exp_isplay());
    check({where, ".anim"},    animation_state, exp_anim());
    check({where, ".burning"}, burning,         exp_burn());
  endtask

  // One clock cycle: drive inputs, advance model on the edge, compare after it.
  task automatic step(input bit tick, input bit en, input bit ig, input bit ex, input string where);
    frame_tick = tick;
    enable     = en;
    ignite     = ig;
    extinguish = ex;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_clock(tick, en, ig, ex);
    #1;
    check_outputs(where);
  endtask

  // One video frame of len cycles with the tick on its first cycle.
  task automatic run_frame(input int len, input bit en, input int ig_at, input int ex_at,
                           input string where);
    for (int c = 0; c < len; c++)
      step(c == 0, en, c == ig_at, c == ex_at, where);
  endtask

  task automatic async_reset_check(input string where);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({where, ".isplay"},  isplay,          0);
    check({where, ".anim"},    animation_state, 0);
    check({where, ".burning"}, burning,         0);
    check({where, ".posx"},    posx,            40);
    check({where, ".posy"},    posy,            260);
    for (int i = 0; i < 6; i++)
      step($urandom_range(0, 1) == 1 && i % 2 == 0, 1'b1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, {where, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b1;
    ignite     = 1'b0;
    extinguish = 1'b0;
    model_reset();
    #12;
    check("rst.isplay",  isplay,          0);
    check("rst.anim",    animation_state, 0);
    check("rst.burning", burning,         0);
    check("rst.posx",    posx,            40);
    check("rst.posy",    posy,            260);
    rst_n = 1'b1;

    // Ignition blink through into three burning toggles.
    run_frame(5, 1'b1, -1, -1, "idle");
    run_frame(6, 1'b1, 2, -1, "ign_evt");
    for (int j = 0; j <= 42; j++) run_frame(4, 1'b1, -1, -1, "ign_burn");

    // Simultaneous events while burning, then while off.
    run_frame(5, 1'b1, 2, 2, "both_burn");
    run_frame(5, 1'b1, -1, -1, "both_burn_after");
    check("both_burn.off_isplay", isplay, 0);
    run_frame(5, 1'b1, 1, 1, "both_off");
    run_frame(5, 1'b1, -1, -1, "both_off_after");
    check("both_off.off_isplay", isplay, 0);

    // Pause at k+20 with an extinguish arriving while paused.
    run_frame(4, 1'b1, 1, -1, "pause_ign");
    for (int j = 0; j <= 20; j++) run_frame(4, 1'b1, -1, -1, "pause_pre");
    for (int j = 0; j < 10; j++)  run_frame(4, 1'b0, -1, (j == 3) ? 2 : -1, "pause_hold");
    run_frame(4, 1'b1, -1, -1, "pause_resume");
    check("pause.off_burning", burning, 0);

    // Ignite late in a long frame: nothing visible until the next tick.
    run_frame(150, 1'b1, 100, -1, "midframe");
    run_frame(4, 1'b1, -1, -1, "midframe_next");

    // Asynchronous reset mid-burn.
    for (int j = 0; j < 25; j++) run_frame(3, 1'b1, -1, -1, "pre_reset");
    async_reset_check("rst_midburn");

    // Random frames, enables and events.
    for (int j = 0; j < 200; j++) begin
      int len;
      int ig_at;
      int ex_at;
      bit en;
      len   = $urandom_range(2, 12);
      en    = ($urandom_range(0, 9) != 0);
      ig_at = ($urandom_range(0, 99) < 25) ? int'($urandom_range(0, len - 1)) : -1;
      ex_at = ($urandom_range(0, 99) < 5)  ? int'($urandom_range(0, len - 1)) : -1;
      run_frame(len, en, ig_at, ex_at, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
